booth_div_seq: RTL and testbench

- Multi-cycle integer divider for the MiniSRC datapath; the inverse of the combinational Booth multiplier.
- Takes a 32-bit dividend and divisor; produces quotient (LO) and remainder (HI) packed into one 64-bit result, matching the multiplier's HI/LO result layout.
- Non-restoring radix-2 algorithm on operand magnitudes, one quotient bit per cycle, followed by a sign/remainder fix-up cycle.
- Driven by the control unit through a start/busy/done handshake.

---
 rtl/booth_div_seq.sv | 105 ++++++++++
 tb/tb_booth_div_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/booth_div_seq.sv
// booth_div_seq: multi-cycle non-restoring radix-2 divider, result = {remainder, quotient}
module booth_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sign_op,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH:0] p_q, p_d, p_sh, p_it, p_fx;
    logic [WIDTH-1:0] q_q, q_d, d_q, d_d, quo, rem;
    logic [CW-1:0] cnt_q, cnt_d;
    logic negq_q, negq_d, negr_q, negr_d;
    logic busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    always_comb begin
        p_sh = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        p_it = p_q[WIDTH] ? p_sh + {1'b0, d_q} : p_sh - {1'b0, d_q};
        p_fx = p_q[WIDTH] ? p_q + {1'b0, d_q} : p_q;
        quo = negq_q ? -q_q : q_q;
        rem = negr_q ? -p_fx[WIDTH-1:0] : p_fx[WIDTH-1:0];
        state_d = state_q;
        p_d = p_q;
        q_d = q_q;
        d_d = d_q;
        cnt_d = cnt_q;
        negq_d = negq_q;
        negr_d = negr_q;
        dbz_d = dbz_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    negq_d = sign_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    negr_d = sign_op & dividend[WIDTH-1];
                    q_d = (sign_op & dividend[WIDTH-1]) ? -dividend : dividend;
                    d_d = (sign_op & divisor[WIDTH-1]) ? -divisor : divisor;
                    p_d = '0;
                    cnt_d = '0;
                    state_d = ITER;
                    if (divisor == '0) begin
                        state_d = DONE;
                        result_d = {dividend, {WIDTH{1'b1}}};
                        dbz_d = 1'b1;
                    end
                end
            end
            ITER: begin
                p_d = p_it;
                q_d = {q_q[WIDTH-2:0], ~p_it[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : ITER;
            end
            FIX: begin
                result_d = {rem, quo};
                dbz_d = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ITER) || (state_d == FIX);
        done_d = (state_d == DONE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q <= '0;
            q_q <= '0;
            d_q <= '0;
            cnt_q <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            p_q <= p_d;
            q_q <= q_d;
            d_q <= d_d;
            cnt_q <= cnt_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dbz_q <= dbz_d;
            result_q <= result_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign div_by_zero = dbz_q;
    assign result = result_q;
endmodule

// File: tb/tb_booth_div_seq.sv
// tb_booth_div_seq: scoreboard bench for booth_div_seq with directed divide vectors
module tb_booth_div_seq;
    logic clk = 0, rst_n = 0, start = 0, sign_op = 0;
    logic [31:0] dividend = 0, divisor = 0;
    logic busy, done, div_by_zero;
    logic [63:0] result;
    typedef struct {logic [63:0] res; logic dbz; int cyc;} exp_t;
    exp_t sb[$];
    exp_t e;
    int errors = 0, checks = 0, cyc = 0;
    logic prev_done = 0;

    booth_div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sign_op(sign_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expectation, including its arrival cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) chk("done_pulse_len", {63'd0, done}, 64'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got result %h expected no completion", result);
                end else begin
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
                    chk("latency", 64'(cyc), 64'(e.cyc));
                    chk("busy_at_done", {63'd0, busy}, 64'd0);
                end
            end
        end
        prev_done <= done;
    end

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic dbz);
        @(negedge clk);
        sign_op = s; dividend = a; divisor = b; start = 1;
        sb.push_back('{res: {r, q}, dbz: dbz, cyc: cyc + 1 + (dbz ? 0 : 33)});
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("rst_result", result, 64'd0);
        rst_n = 1;

        issue(1, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        repeat (10) @(negedge clk);
        chk("busy_mid", {63'd0, busy}, 64'd1);
        drain();
        issue(1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0); drain();
        issue(1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 0); drain();
        issue(0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 0); drain();
        issue(1, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 0); drain();
        issue(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0); drain();
        issue(1, 32'd1234, 32'd0, 32'hFFFFFFFF, 32'h000004D2, 1); drain();
        issue(0, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd7, 1); drain();

        // Start while busy is ignored; start in the done cycle is accepted
        issue(1, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        repeat (4) @(negedge clk);
        sign_op = 1; dividend = 32'd9; divisor = 32'd3; start = 1;
        @(negedge clk);
        start = 0; dividend = 32'd77; divisor = 32'd5;
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_wait: got done=0 expected 1");
        end else begin
            sign_op = 1; dividend = 32'd9; divisor = 32'd3; start = 1;
            sb.push_back('{res: {32'd0, 32'd3}, dbz: 1'b0, cyc: cyc + 34});
            @(posedge clk);
            #1 start = 0;
        end
        drain();

        // Async reset mid-operation discards the op
        @(negedge clk);
        sign_op = 1; dividend = 32'd100; divisor = 32'd7; start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (9) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1;
        issue(1, 32'd50, 32'd5, 32'd10, 32'd0, 0); drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
